lock_out_slew: RTL
==================

LOCK_OUT_SLEW -- requirements
Module: lock_out_slew

Interface
REQ-001 Parameter: PW, 16, prescaler width in bits.
REQ-002 Port: clk_i  input  1  clock; all logic on rising edge.
REQ-003 Port: rstn_i  input  1  synchronous active-high reset.
REQ-004 Port: enable_i  input  1  output stage enable.
REQ-005 Port: hold_i  input  1  freeze dat_o.
REQ-006 Port: dat_i  input  14  signed PID output, from lock_pid_block dat_o.
REQ-007 Port: offset_i  input  14  signed DC offset added to dat_i.
REQ-008 Port: lim_min_i  input  14  signed lower output limit.
REQ-009 Port: lim_max_i  input  14  signed upper output limit.
REQ-010 Port: step_i  input  14  unsigned max change per tick; 0 = unlimited.
REQ-011 Port: presc_i  input  PW  unsigned tick period minus 1.
REQ-012 Port: dat_o  output  14  signed registered output to DAC.
REQ-013 Port: state_o  output  2  FSM state: OFF=0, RAMP=1, TRACK=2; 3 never driven.
REQ-014 Port: at_lim_o  output  1  registered clamp-active flag.
REQ-015 Port: ramping_o  output  1  high iff state_o==RAMP.

Function
REQ-016 Sum: 15-bit signed sum = dat_i + offset_i; no wrap at any width.
REQ-017 Clamp: sum above lim_max_i gives lim_max_i, then sum below lim_min_i gives lim_min_i; if lim_min_i > lim_max_i, result is lim_min_i.
REQ-018 Target register: clamped value, registered 1 cycle after inputs; in OFF, target register = 0, not clamped.
REQ-019 at_lim_o: registered with target; 1 when sum lies outside [lim_min_i, lim_max_i]; 0 in OFF.
REQ-020 Prescaler: counter 0..presc_i; tick when cnt >= presc_i, then cnt := 0; presc_i=0 gives a tick every cycle; lowering presc_i below cnt gives a tick next cycle.
REQ-021 Update on tick only, hold_i=0: diff = target - dat_o (16-bit signed); step_i==0 or |diff| <= step_i gives dat_o := target; else dat_o := dat_o + step_i (diff>0) or dat_o - step_i (diff<0).
REQ-022 dat_o moves only toward target, never overshoots, never leaves 14-bit range.
REQ-023 hold_i=1: dat_o unchanged; prescaler and FSM keep running; release resumes at the next tick.
REQ-024 FSM OFF -> RAMP: enable_i=1.
REQ-025 FSM RAMP -> TRACK: tick where dat_o reaches target (|diff| <= step_i or step_i==0) and hold_i=0.
REQ-026 FSM TRACK -> RAMP: tick where |diff| > step_i (step_i != 0).
REQ-027 FSM any -> OFF: enable_i=0, same cycle as sampled; takes priority over other transitions.
REQ-028 OFF output: dat_o slews toward 0 at the step_i rate (smooth release); hold_i still freezes.
REQ-029 Latency: dat_i change to dat_o change, 2 cycles minimum at presc_i=0 (target reg + output reg).
REQ-030 All inputs are sampled every cycle; mid-ramp changes to step_i, limits or offset take effect at the next target/tick.

Reset
REQ-031 rstn_i=1: dat_o=0, target=0, cnt=0, state OFF, at_lim_o=0, ramping_o=0, all on the next edge.
REQ-032 Reset mid-ramp: abandons the ramp immediately; no residual step after rstn_i falls.
REQ-033 Reset overrides hold_i and enable_i.

Verification
REQ-034 Pass-through: presc=0, step=0, limits ±8191, offset=0, enable=1, dat_i=1000 -> dat_o=1000 two cycles later; state TRACK.
REQ-035 Slew: presc=9, step=100, dat_i 0->1000 -> dat_o +100 every 10 clocks, reaches 1000 after 10 ticks; ramping_o=1 during, then TRACK.
REQ-036 Clamp: lim_max=2000, dat_i=1500, offset=1000, step=0 -> dat_o=2000, at_lim_o=1; lim_min=3000 > lim_max -> dat_o=3000.
REQ-037 Overflow: dat_i=8191, offset=8191, lim_max=8191 -> dat_o=8191 without wrap; dat_i=offset=-8192 -> dat_o=lim_min.
REQ-038 Hold/disable: hold_i=1 mid-ramp at dat_o=500 -> stays 500 for hold duration; enable=0, step=50, presc=0 -> state OFF, dat_o falls 50/cycle to 0.
REQ-039 Reset mid-ramp: rstn_i=1 for 1 cycle at dat_o=700 -> dat_o=0, state OFF, cnt=0 next edge.

Source files
------------

// File: rtl/lock_out_slew.sv
// Output slew stage: offset, clamp, rate-limit toward target, OFF/RAMP/TRACK FSM.
// Latency: 2 cycles dat_i -> dat_o at presc_i=0 (target reg + output reg).
// Backpressure: none; all inputs sampled every cycle, hold_i freezes dat_o only.
module lock_out_slew #(
    parameter int PW = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enable_i,
    input  logic                 hold_i,
    input  logic signed [13:0]   dat_i,
    input  logic signed [13:0]   offset_i,
    input  logic signed [13:0]   lim_min_i,
    input  logic signed [13:0]   lim_max_i,
    input  logic        [13:0]   step_i,
    input  logic        [PW-1:0] presc_i,
    output logic signed [13:0]   dat_o,
    output logic        [1:0]    state_o,
    output logic                 at_lim_o,
    output logic                 ramping_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RAMP  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [13:0]   target_q, dat_q, dat_d, clamp_val;
    logic                 at_lim_q;
    logic        [PW-1:0] cnt_q;

    logic signed [14:0]   sum, lmin15, lmax15;
    logic                 above, below, tick, reach;
    logic signed [15:0]   diff;
    logic        [15:0]   abs_diff;

    // 15-bit sum cannot wrap for any pair of 14-bit operands
    assign sum    = {dat_i[13], dat_i} + {offset_i[13], offset_i};
    assign lmin15 = {lim_min_i[13], lim_min_i};
    assign lmax15 = {lim_max_i[13], lim_max_i};
    assign above  = sum > lmax15;
    assign below  = sum < lmin15;

    // Max clamp first, then min clamp, so an inverted window resolves to lim_min_i
    always_comb begin
        clamp_val = sum[13:0];
        if (above) begin
            clamp_val = (lim_max_i < lim_min_i) ? lim_min_i : lim_max_i;
        end else if (below) begin
            clamp_val = lim_min_i;
        end
    end

    assign tick     = cnt_q >= presc_i;
    assign diff     = {{2{target_q[13]}}, target_q} - {{2{dat_q[13]}}, dat_q};
    assign abs_diff = diff[15] ? 16'(-diff) : 16'(diff);
    assign reach    = (step_i == 14'd0) || (abs_diff <= {2'b00, step_i});

    // A partial step only happens when |diff| > step_i, so it never overshoots
    always_comb begin
        dat_d = dat_q;
        if (tick && !hold_i) begin
            if (reach) begin
                dat_d = target_q;
            end else if (!diff[15]) begin
                dat_d = dat_q + step_i;
            end else begin
                dat_d = dat_q - step_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_RAMP;
                ST_RAMP:  if (tick && !hold_i && reach) state_d = ST_TRACK;
                ST_TRACK: if (tick && !reach) state_d = ST_RAMP;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q  <= ST_OFF;
            target_q <= '0;
            at_lim_q <= 1'b0;
            dat_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            // Disabled: target parks at 0 so dat_o releases smoothly to zero
            target_q <= enable_i ? clamp_val : 14'sd0;
            at_lim_q <= enable_i && (above || below);
            dat_q    <= dat_d;
            cnt_q    <= tick ? '0 : cnt_q + 1'b1;
        end
    end

    assign dat_o     = dat_q;
    assign state_o   = state_q;
    assign at_lim_o  = at_lim_q;
    assign ramping_o = (state_q == ST_RAMP);

endmodule
